arm_multicycle_controller: RTL and testbench
============================================

# arm_multicycle_controller

Control unit for the multicycle ARM datapath: sequences each instruction through fetch, decode, execute, memory and writeback states over one shared memory and ALU. It decodes the instruction register, holds the NZCV condition flags, evaluates condition codes, and drives every datapath select and write enable. It sits beside the multicycle datapath inside `arm` and replaces the single-cycle decoder.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `Instr`  in  20  instruction register bits [31:12]: cond, op, funct, Rd
- `ALUFlags`  in  4  ALU result flags {N,Z,C,V} from the current cycle
- `PCWrite`  out  1  PC register enable
- `MemWrite`  out  1  data memory write enable
- `RegWrite`  out  1  register file write enable
- `IRWrite`  out  1  instruction register enable
- `AdrSrc`  out  1  memory address: 0=PC, 1=ALUOut
- `ALUSrcA`  out  1  0=RD1 (Rn), 1=PC
- `ALUSrcB`  out  2  00=RD2, 01=ExtImm, 10=constant 4
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALU result
- `RegSrc`  out  2  [0]=1 reads R15 as Rn (branch); [1]=1 reads Rd as Rm (STR)
- `ImmSrc`  out  2  equals op: 00=imm8, 01=imm12, 10=imm24
- `ALUControl`  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- `State`  out  4  current FSM state encoding, for verification

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op=00 goes to EXECUTEI if I=1, otherwise EXECUTER; op=01 goes to MEMADR; op=10 goes to BRANCH; op=11 goes to FETCH.
  - MEMADR→MEMRD if L=1, otherwise MEMWR.
  - MEMRD→MEMWB. EXECUTER and EXECUTEI→ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH→FETCH.
- Per-state signals (any signal not listed is 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 gives ADD with FlagW=00.
  - ALUOp=1 decodes cmd=Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - FlagW[1]=S (updates NZ). FlagW[0]=S & (ADD|SUB) (updates CV).
  - Unsupported cmd: ALUControl=00, FlagW=00, NoWrite=1.
- Condition evaluation:
  - Standard ARM cond 0000–1110 is evaluated against the internal Flags register.
  - cond=1111 evaluates false.
  - CondEx is latched at the end of DECODE and held until the next DECODE.
- Flags update: Flags[3:2]←ALUFlags[3:2] if FlagW[1]&CondEx; Flags[1:0]←ALUFlags[1:0] if FlagW[0]&CondEx. Updates happen only at the edge leaving EXECUTER or EXECUTEI.
- Gated outputs:
  - PCWrite = NextPC | (PCS & CondEx), where PCS = Branch | (RegW & Rd==15).
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
- A condition-failed instruction walks the same states with all writes suppressed; IRWrite and NextPC in FETCH are unaffected.

## Timing
- Reset: while `reset`=1, the next state is FETCH and Flags=0000, CondEx=0.
- During reset, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0. The other outputs take their FETCH values and `State`=0.
- Reset asserted in any state: FETCH on the next edge, with no write or flag update at that edge.
- All outputs are combinational from State, Instr and latched CondEx/Flags; there are no extra output registers.
- Instruction latency in cycles: DP=4, LDR=5, STR=4, B=3, op=11=2.
- Flags written in EXECUTE are visible to the condition check of the next instruction's DECODE.

## Configuration
- `ARM_CMP_EN` defined: cmd=1010 with S=1 decodes as SUB with FlagW=11, NoWrite=1. The result is compare-only: flags update, no register write.
- `ARM_CMP_EN` undefined: cmd=1010 is handled as an unsupported cmd: ALUControl=00, no flag update, no register write.

## Test plan
- Reset for 3 cycles, then Instr=0xE2802 (ADD R2,R0,#5) → State 0,1,7,8,0; ALUControl=00 and ALUSrcB=01 in state 7; RegWrite=1 only in state 8; PCWrite=1 only in state 0.
- Instr=0xE2500 (SUBS R0,R0,#1) with ALUFlags=0100 in EXECUTEI, then Instr=0x0A000 (BEQ) → ALUControl=01; the BEQ takes states 0,1,9 with PCWrite=1 in state 9.
- Same BEQ after flags were cleared to 0000 → PCWrite=0 in BRANCH; RegWrite and MemWrite stay 0 throughout.
- Instr=0xE5902 (LDR R2,[R0,#0]) → states 0,1,2,3,4; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4. Instr=0xE5837 (STR) → MemWrite=1 and RegSrc=10 in state 5.
- Reset asserted during MEMRD of an LDR → next State=0; no RegWrite or MemWrite pulse; Flags=0000.
- Instr=0xE3500 (CMP R0,#0) with ALUFlags=0110:
  - with `ARM_CMP_EN`: ALUControl=01, RegWrite=0, Flags=0110 afterwards.
  - without `ARM_CMP_EN`: ALUControl=00, RegWrite=0, Flags unchanged.

Source files
------------

// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller: FSM-based control unit for the multicycle ARM
// datapath. Decodes cond/op/funct/Rd, holds the NZCV flags, evaluates the
// condition code once per instruction in DECODE and gates every write enable.
// Optional feature macro: ARM_CMP_EN (decode cmd=1010 with S=1 as CMP).
module arm_multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      state_q, state_d, cur_s;
    logic [3:0]  flags_q, flags_d;
    logic        condex_q, condex_d;

    // Instruction fields, indexed relative to Instr[31:12]
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign cmd       = funct[4:1];
    assign s_bit     = funct[0];
    assign unused_rn = ^Instr[7:4];

    // While reset is held the outputs look like FETCH
    assign cur_s = reset ? S_FETCH : state_q;

    logic next_pc, branch, reg_w, mem_w, ir_w, alu_op;
    logic [1:0] dp_alc, dp_flagw, flag_w;
    logic dp_nowrite, no_write, cond_ok, pcs;

    // Condition-code evaluation against the held NZCV flags
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_holds = z;
            4'b0001: cond_holds = ~z;
            4'b0010: cond_holds = cf;
            4'b0011: cond_holds = ~cf;
            4'b0100: cond_holds = n;
            4'b0101: cond_holds = ~n;
            4'b0110: cond_holds = v;
            4'b0111: cond_holds = ~v;
            4'b1000: cond_holds = cf & ~z;
            4'b1001: cond_holds = ~(cf & ~z);
            4'b1010: cond_holds = (n == v);
            4'b1011: cond_holds = (n != v);
            4'b1100: cond_holds = ~z & (n == v);
            4'b1101: cond_holds = ~(~z & (n == v));
            4'b1110: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_holds(cond, flags_q);

    // Main decoder: per-state datapath selects and ungated enables, plus next state
    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        state_d   = S_FETCH;
        case (cur_s)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU decoder: operation, flag-write mask and register-write suppression
    always_comb begin
        dp_alc     = 2'b00;
        dp_flagw   = 2'b00;
        dp_nowrite = 1'b0;
        case (cmd)
            4'b0100: begin dp_alc = 2'b00; dp_flagw = {s_bit, s_bit}; end
            4'b0010: begin dp_alc = 2'b01; dp_flagw = {s_bit, s_bit}; end
            4'b0000: begin dp_alc = 2'b10; dp_flagw = {s_bit, 1'b0}; end
            4'b1100: begin dp_alc = 2'b11; dp_flagw = {s_bit, 1'b0}; end
`ifdef ARM_CMP_EN
            4'b1010: begin
                dp_nowrite = 1'b1;
                if (s_bit) begin
                    dp_alc   = 2'b01;
                    dp_flagw = 2'b11;
                end
            end
`endif
            default: dp_nowrite = 1'b1;
        endcase
    end

    assign ALUControl = alu_op ? dp_alc : 2'b00;
    assign flag_w     = alu_op ? dp_flagw : 2'b00;
    // Suppression must reach ALUWB, where the ALU decoder is no longer selected
    assign no_write   = (op == 2'b00) & dp_nowrite;

    // Next values of the flags (only on leaving EXECUTE) and the latched condition
    always_comb begin
        flags_d  = flags_q;
        condex_d = condex_q;
        if (state_q == S_EXECUTER || state_q == S_EXECUTEI) begin
            if (flag_w[1] & condex_q) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0] & condex_q) flags_d[1:0] = ALUFlags[1:0];
        end
        if (state_q == S_DECODE) condex_d = cond_ok;
    end

    // State, flags and condition registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    assign pcs        = branch | (reg_w & (rd == 4'd15));
    assign PCWrite    = ~reset & (next_pc | (pcs & condex_q));
    assign RegWrite   = ~reset & reg_w & condex_q & ~no_write;
    assign MemWrite   = ~reset & mem_w & condex_q;
    assign IRWrite    = ~reset & ir_w;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign ImmSrc     = op;
    assign State      = cur_s;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb_arm_multicycle_controller: directed stimulus for the multicycle controller.
// Expected outputs per cycle go through a scoreboard queue and are compared
// with immediate assertions half a clock after each rising edge.
module tb_arm_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl;
    logic [3:0]  State;

    int checks = 0;
    int errors = 0;

`ifdef ARM_CMP_EN
    localparam logic [1:0] CMP_ALC   = 2'b01;
    localparam logic       CMP_TAKEN = 1'b1;
`else
    localparam logic [1:0] CMP_ALC   = 2'b00;
    localparam logic       CMP_TAKEN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] we;      // {PCWrite, MemWrite, RegWrite, IRWrite}
        logic [5:0] sel;     // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
        logic [1:0] alc;
        logic [1:0] regsrc;
        logic [1:0] immsrc;
    } exp_t;

    exp_t sb[$];

    arm_multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegSrc(RegSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    // Select table per state: {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
    function automatic logic [5:0] sel_for(input logic [3:0] st);
        case (st)
            4'd0:    sel_for = {1'b0, 1'b1, 2'b10, 2'b10};
            4'd1:    sel_for = {1'b0, 1'b1, 2'b10, 2'b10};
            4'd2:    sel_for = {1'b0, 1'b0, 2'b01, 2'b00};
            4'd3:    sel_for = {1'b1, 1'b0, 2'b00, 2'b00};
            4'd4:    sel_for = {1'b0, 1'b0, 2'b00, 2'b01};
            4'd5:    sel_for = {1'b1, 1'b0, 2'b00, 2'b00};
            4'd7:    sel_for = {1'b0, 1'b0, 2'b01, 2'b00};
            4'd9:    sel_for = {1'b0, 1'b0, 2'b01, 2'b10};
            default: sel_for = 6'b000000;
        endcase
    endfunction

    // One clock cycle: queue the expectation, compare, advance to next falling edge
    task automatic step(input logic [3:0] st, input logic pcw, input logic mw,
                        input logic rw, input logic [1:0] alc);
        exp_t e;
        exp_t g;
        e.st     = st;
        e.we     = {pcw, mw, rw, (st == 4'd0) && !reset};
        e.sel    = sel_for(st);
        e.alc    = alc;
        e.regsrc = {Instr[15:14] == 2'b01, Instr[15:14] == 2'b10};
        e.immsrc = Instr[15:14];
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        checks++;
        assert (State === g.st) else begin
            errors++; $error("FAIL state: got %0d expected %0d (instr %h)", State, g.st, Instr);
        end
        checks++;
        assert ({PCWrite, MemWrite, RegWrite, IRWrite} === g.we) else begin
            errors++; $error("FAIL write_en: got %b expected %b (state %0d instr %h)",
                             {PCWrite, MemWrite, RegWrite, IRWrite}, g.we, g.st, Instr);
        end
        checks++;
        assert ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} === g.sel) else begin
            errors++; $error("FAIL selects: got %b expected %b (state %0d)",
                             {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, g.sel, g.st);
        end
        checks++;
        assert (ALUControl === g.alc) else begin
            errors++; $error("FAIL alu_control: got %b expected %b (state %0d instr %h)",
                             ALUControl, g.alc, g.st, Instr);
        end
        checks++;
        assert (RegSrc === g.regsrc) else begin
            errors++; $error("FAIL reg_src: got %b expected %b", RegSrc, g.regsrc);
        end
        checks++;
        assert (ImmSrc === g.immsrc) else begin
            errors++; $error("FAIL imm_src: got %b expected %b", ImmSrc, g.immsrc);
        end
        @(negedge clk);
    endtask

    // SUBS R0,R0,#1 with the given flags presented during EXECUTEI
    task automatic subs(input logic [3:0] f);
        Instr = 20'hE2500;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        ALUFlags = f;
        step(4'd7, 1'b0, 1'b0, 1'b0, 2'b01);
        ALUFlags = 4'b0000;
        step(4'd8, 1'b0, 1'b0, 1'b1, 2'b00);
    endtask

    // BEQ: PC write in BRANCH only when Z is set
    task automatic beq(input logic taken);
        Instr = 20'h0A000;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd9, taken, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 20'hE2802;
        ALUFlags = 4'b0000;
        @(negedge clk);
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step(4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;

        // ADD R2,R0,#5
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd8, 1'b0, 1'b0, 1'b1, 2'b00);

        // SUBS sets Z, BEQ taken; then clear flags, BEQ not taken
        subs(4'b0100);
        beq(1'b1);
        subs(4'b0000);
        beq(1'b0);

        // Condition never (cond=1111): ADD walks states with no register write
        Instr = 20'hF2802;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);

        // ADD R15: ALUWB also writes the PC
        Instr = 20'hE280F;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd8, 1'b1, 1'b0, 1'b1, 2'b00);

        // op=11: two-cycle no-op
        Instr = 20'hEC000;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);

        // LDR R2,[R0,#0]
        Instr = 20'hE5902;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd4, 1'b0, 1'b0, 1'b1, 2'b00);

        // STR R7
        Instr = 20'hE5837;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd5, 1'b0, 1'b1, 1'b0, 2'b00);

        // Set Z, then reset during MEMRD of an LDR: flags must be cleared
        subs(4'b0100);
        Instr = 20'hE5902;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        step(4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        beq(1'b0);

        // CMP R0,#0 with ALUFlags Z and C set
        Instr = 20'hE3500;
        step(4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        ALUFlags = 4'b0110;
        step(4'd7, 1'b0, 1'b0, 1'b0, CMP_ALC);
        ALUFlags = 4'b0000;
        step(4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        beq(CMP_TAKEN);

        checks++;
        assert (sb.size() == 0) else begin
            errors++; $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
